// File: rtl/audio_pkg.sv
// Shared constants for the serial audio transmitter: format encodings and frame geometry.
package audio_pkg;

    localparam logic [1:0] MODE_I2S  = 2'd0;
    localparam logic [1:0] MODE_LJ   = 2'd1;
    localparam logic [1:0] MODE_RJ   = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    function automatic int frame_bits(input int channels, input int slot_w);
        return channels * slot_w;
    endfunction

endpackage

// File: rtl/audio_frame_shifter.sv
// Formats one frame into slots at load and shifts it out MSB-first on bit-clock falls.
// Latency: LJ/RJ bit appears on the load fall itself; I2S adds one fall of delay.
// Backpressure: none; driven purely by fall/load strobes from the top level.
module audio_frame_shifter
    import audio_pkg::*;
#(
    parameter int AUDIO_DW = 16,
    parameter int SLOT_W   = 32,
    parameter int CHANNELS = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         fall,
    input  logic                         load,
    input  logic [1:0]                   mode,
    input  logic [CHANNELS*AUDIO_DW-1:0] frame,
    output logic                         sdata
);

    localparam int FRAME_BITS = frame_bits(CHANNELS, SLOT_W);

    logic [FRAME_BITS-1:0] shift_q;
    logic [FRAME_BITS-1:0] frame_vec;
    logic [AUDIO_DW-1:0]   smp;
    logic [SLOT_W-1:0]     slot;
    logic                  i2s_q;
    logic                  dly_q;
    logic                  raw_bit;
    logic                  use_i2s;
    logic                  load_rj;

    assign load_rj = (mode == MODE_RJ);

    // Channel 0 occupies the most significant slot so it leaves the shifter first.
    always_comb begin
        frame_vec = '0;
        smp       = '0;
        slot      = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            smp = frame[k*AUDIO_DW +: AUDIO_DW];
            if (load_rj) begin
                slot = SLOT_W'({{SLOT_W{smp[AUDIO_DW-1]}}, smp});
            end else begin
                slot = SLOT_W'({smp, {SLOT_W{1'b0}}} >> AUDIO_DW);
            end
            frame_vec[(CHANNELS-1-k)*SLOT_W +: SLOT_W] = slot;
        end
    end

    assign raw_bit = load ? frame_vec[FRAME_BITS-1] : shift_q[FRAME_BITS-1];
    assign use_i2s = load ? ((mode == MODE_I2S) || (mode == MODE_RSVD)) : i2s_q;

    // dly_q always tracks the undelayed stream so I2S picks up the previous frame's last bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q <= '0;
            i2s_q   <= 1'b0;
            dly_q   <= 1'b0;
            sdata   <= 1'b0;
        end else if (fall) begin
            if (load) begin
                shift_q <= frame_vec << 1;
                i2s_q   <= use_i2s;
            end else begin
                shift_q <= shift_q << 1;
            end
            dly_q <= raw_bit;
            sdata <= use_i2s ? dly_q : raw_bit;
        end
    end

endmodule

// File: rtl/audio_tdm_tx.sv
// Multi-channel I2S/LJ/RJ/TDM transmitter with a one-frame holding register ahead of the shifter.
// Latency: an accepted frame starts on the next p==0 load; frame_start/underrun are registered pulses.
// Backpressure: sample_ready drops while holding is full, reopening on the load that drains it.
module audio_tdm_tx
    import audio_pkg::*;
#(
    parameter int AUDIO_DW = 16,
    parameter int SLOT_W   = 32,
    parameter int CHANNELS = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         ce,
    input  logic [1:0]                   mode,
    input  logic [CHANNELS*AUDIO_DW-1:0] samples,
    input  logic                         sample_valid,
    output logic                         sample_ready,
    output logic                         sclk,
    output logic                         lrclk,
    output logic                         sdata,
    output logic                         frame_start,
    output logic                         underrun
);

    localparam int FRAME_BITS = frame_bits(CHANNELS, SLOT_W);
    localparam int PW         = $clog2(FRAME_BITS);
    localparam logic [PW-1:0] P_LAST = PW'(FRAME_BITS - 1);
    localparam logic [PW-1:0] P_HALF = PW'(FRAME_BITS / 2);

    logic [PW-1:0]                p;
    logic                         fall_evt;
    logic                         load_evt;
    logic                         accept;
    logic                         hold_full;
    logic [CHANNELS*AUDIO_DW-1:0] hold_dat;
    logic [CHANNELS*AUDIO_DW-1:0] load_dat;

    assign fall_evt     = ce && sclk;
    assign load_evt     = fall_evt && (p == '0);
    assign sample_ready = !hold_full || load_evt;
    assign accept       = sample_valid && sample_ready;
    assign load_dat     = hold_full ? hold_dat : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk  <= 1'b1;
            p     <= '0;
            lrclk <= 1'b0;
        end else if (ce) begin
            sclk <= !sclk;
            if (sclk) begin
                p     <= (p == P_LAST) ? '0 : p + 1'b1;
                lrclk <= (p >= P_HALF);
            end
        end
    end

    // A load with valid present swaps in the same cycle: old frame out, new frame in.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_full <= 1'b0;
            hold_dat  <= '0;
        end else begin
            if (accept) begin
                hold_full <= 1'b1;
                hold_dat  <= samples;
            end else if (load_evt) begin
                hold_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= load_evt;
            underrun    <= load_evt && !hold_full;
        end
    end

    audio_frame_shifter #(
        .AUDIO_DW (AUDIO_DW),
        .SLOT_W   (SLOT_W),
        .CHANNELS (CHANNELS)
    ) u_shifter (
        .clk     (clk),
        .reset_n (reset_n),
        .fall    (fall_evt),
        .load    (load_evt),
        .mode    (mode),
        .frame   (load_dat),
        .sdata   (sdata)
    );

endmodule

// File: tb/tb_audio_tdm_tx.sv
// Scoreboard bench: three transmitter geometries, accepted frames queued and replayed by a bit-level model.
module tb_audio_tdm_tx;
    import audio_pkg::*;

    localparam int NI = 3;
    localparam int AW = 16;

    typedef struct {
        int          cyc;
        logic [127:0] dat;
    } acc_t;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               ce, ce_en, ce_rand, mon_en;
    logic [1:0]         mode_r    [NI];
    logic [1:0]         mode_edge [NI];
    logic [127:0]       smp       [NI];
    logic [NI-1:0]      valid, allow, took, valid_edge;
    wire  [NI-1:0]      ready, sclk_w, lrclk_w, sdata_w, fs_w, ur_w;

    acc_t               acc_q [NI][$];
    logic [127:0]       dir_q [NI][$];
    acc_t               push_tmp, pop_tmp;

    int                 pos [NI], loads [NI], unders [NI];
    logic [127:0]       cur [NI];
    logic [1:0]         cur_mode [NI];
    logic               rawprev [NI], psclk [NI];
    int                 cyc, chk, errs;

    audio_tdm_tx #(.AUDIO_DW(16), .SLOT_W(32), .CHANNELS(2)) dut0 (
        .clk(clk), .reset_n(reset_n), .ce(ce), .mode(mode_r[0]), .samples(smp[0][31:0]),
        .sample_valid(valid[0]), .sample_ready(ready[0]), .sclk(sclk_w[0]), .lrclk(lrclk_w[0]),
        .sdata(sdata_w[0]), .frame_start(fs_w[0]), .underrun(ur_w[0]));

    audio_tdm_tx #(.AUDIO_DW(16), .SLOT_W(16), .CHANNELS(8)) dut1 (
        .clk(clk), .reset_n(reset_n), .ce(ce), .mode(mode_r[1]), .samples(smp[1]),
        .sample_valid(valid[1]), .sample_ready(ready[1]), .sclk(sclk_w[1]), .lrclk(lrclk_w[1]),
        .sdata(sdata_w[1]), .frame_start(fs_w[1]), .underrun(ur_w[1]));

    audio_tdm_tx #(.AUDIO_DW(16), .SLOT_W(24), .CHANNELS(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .ce(ce), .mode(mode_r[2]), .samples(smp[2][31:0]),
        .sample_valid(valid[2]), .sample_ready(ready[2]), .sclk(sclk_w[2]), .lrclk(lrclk_w[2]),
        .sdata(sdata_w[2]), .frame_start(fs_w[2]), .underrun(ur_w[2]));

    function automatic int sw_of(int i);
        return (i == 0) ? 32 : (i == 1) ? 16 : 24;
    endfunction

    function automatic int fb_of(int i);
        return sw_of(i) * ((i == 1) ? 8 : 2);
    endfunction

    // Bit p of a frame as the format rules describe it, before any I2S delay.
    function automatic logic raw_bit(int i, logic [127:0] f, logic rj, int p);
        int sw, k, b;
        logic [AW-1:0] s;
        sw = sw_of(i);
        k  = p / sw;
        b  = p % sw;
        s  = f[k*AW +: AW];
        if (rj) begin
            if (b < sw - AW) return s[AW-1];
            return s[AW-1-(b-(sw-AW))];
        end
        if (b < AW) return s[AW-1-b];
        return 1'b0;
    endfunction

    function automatic logic [127:0] next_frame(int i);
        if (dir_q[i].size() > 0) return dir_q[i].pop_front();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check(string nm, int i, logic [31:0] act, logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s inst%0d t=%0t got %0h expected %0h", nm, i, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            pos[i]      = 0;
            cur[i]      = '0;
            cur_mode[i] = MODE_LJ;
            rawprev[i]  = 1'b0;
            psclk[i]    = 1'b1;
            acc_q[i].delete();
        end
    endtask

    task automatic check_reset(string nm);
        for (int i = 0; i < NI; i++) begin
            check({nm, "_sclk"}, i, sclk_w[i], 1);
            check({nm, "_lrclk"}, i, lrclk_w[i], 0);
            check({nm, "_sdata"}, i, sdata_w[i], 0);
            check({nm, "_frame_start"}, i, fs_w[i], 0);
            check({nm, "_underrun"}, i, ur_w[i], 0);
            check({nm, "_ready"}, i, ready[i], 1);
        end
    endtask

    task automatic wait_loads(int i, int n, int budget, string nm);
        int t;
        t = 0;
        while (loads[i] < n && t < budget) begin
            @(negedge clk);
            #1;
            t++;
        end
        check(nm, i, loads[i] >= n, 1);
    endtask

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        ce = ce_en && (ce_rand ? ($urandom_range(0, 1) == 1) : !ce);
    end

    // Records accepts on the edge, then drives the next stimulus just after it.
    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < NI; i++) begin
            mode_edge[i]  = mode_r[i];
            valid_edge[i] = valid[i] && reset_n;
            took[i]       = reset_n && valid[i] && ready[i];
            if (took[i]) begin
                push_tmp.cyc = cyc;
                push_tmp.dat = smp[i];
                acc_q[i].push_back(push_tmp);
            end
        end
        #1;
        for (int i = 0; i < NI; i++) begin
            if (took[i] || !valid[i]) begin
                if (allow[i] && $urandom_range(0, 3) != 0) begin
                    valid[i] = 1'b1;
                    smp[i]   = next_frame(i);
                end else begin
                    valid[i] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic fall, eload, eund, rb, exp_sd;
        if (mon_en && reset_n) begin
            for (int i = 0; i < NI; i++) begin
                fall     = psclk[i] && !sclk_w[i];
                psclk[i] = sclk_w[i];
                eload    = 1'b0;
                eund     = 1'b0;
                if (fall) begin
                    if (pos[i] == 0) begin
                        eload = 1'b1;
                        if (acc_q[i].size() > 0 && acc_q[i][0].cyc < cyc) begin
                            pop_tmp = acc_q[i].pop_front();
                            cur[i]  = pop_tmp.dat;
                        end else begin
                            cur[i] = '0;
                            eund   = 1'b1;
                            unders[i]++;
                        end
                        cur_mode[i] = mode_edge[i];
                        loads[i]++;
                        if (valid_edge[i])
                            check("accept_at_load", i,
                                  (acc_q[i].size() > 0 && acc_q[i][$].cyc == cyc), 1);
                    end
                    rb = raw_bit(i, cur[i], cur_mode[i] == MODE_RJ, pos[i]);
                    exp_sd = (cur_mode[i] == MODE_I2S || cur_mode[i] == MODE_RSVD) ? rawprev[i] : rb;
                    rawprev[i] = rb;
                    check("sdata", i, sdata_w[i], exp_sd);
                    check("lrclk", i, lrclk_w[i], pos[i] >= fb_of(i) / 2);
                    pos[i] = (pos[i] + 1) % fb_of(i);
                end
                check("frame_start", i, fs_w[i], eload);
                check("underrun", i, ur_w[i], eund);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int t, u0, l0, l1;
        logic [127:0] f1;
        reset_n = 1'b0; ce = 1'b0; ce_en = 1'b0; ce_rand = 1'b0; mon_en = 1'b0;
        valid = '0; allow = '0; took = '0; valid_edge = '0;
        cyc = 0; chk = 0; errs = 0;
        for (int i = 0; i < NI; i++) begin
            smp[i] = '0; mode_r[i] = MODE_LJ; mode_edge[i] = MODE_LJ;
            loads[i] = 0; unders[i] = 0;
        end
        mode_r[2] = MODE_RJ;
        model_reset();

        dir_q[0].push_back({96'd0, 16'h0F0F, 16'hA5F0});
        dir_q[0].push_back({96'd0, 16'h0F0F, 16'hA5F0});
        f1 = '0;
        for (int k = 0; k < 8; k++) f1[k*16 +: 16] = 16'(16'h1000 * k);
        dir_q[1].push_back(f1);
        dir_q[2].push_back({96'd0, 16'h1234, 16'h8001});

        repeat (3) @(negedge clk);
        check_reset("reset");

        @(negedge clk);
        reset_n = 1'b1;
        allow   = '1;
        t = 0;
        while ((acc_q[0].size() == 0 || acc_q[1].size() == 0 || acc_q[2].size() == 0) && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("first_accept", 0, (acc_q[0].size() > 0 && acc_q[1].size() > 0 && acc_q[2].size() > 0), 1);
        mon_en = 1'b1;
        ce_en  = 1'b1;

        wait_loads(0, 1, 400, "first_load");
        mode_r[0] = MODE_I2S;
        wait_loads(0, 3, 1500, "i2s_frames");
        wait_loads(1, 2, 3000, "tdm8_frame");

        ce_rand = 1'b1;
        for (int r = 0; r < 12; r++) begin
            repeat ($urandom_range(100, 500)) @(negedge clk);
            mode_r[$urandom_range(0, 2)] = 2'($urandom_range(0, 3));
        end
        ce_rand = 1'b0;

        u0 = unders[0];
        allow[0] = 1'b0;
        t = 0;
        while (unders[0] == u0 && t < 2000) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("underrun_seen", 0, unders[0] > u0, 1);
        allow[0] = 1'b1;
        wait_loads(0, loads[0] + 2, 1500, "after_underrun");

        t = 0;
        while (pos[0] != 20 && t < 2000) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("reach_p20", 0, pos[0] == 20, 1);
        reset_n = 1'b0;
        mon_en  = 1'b0;
        #1;
        check_reset("midreset");
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) check("ready_after_reset", i, ready[i], 1);
        mon_en = 1'b1;
        l0 = loads[0];
        l1 = loads[1];
        wait_loads(0, l0 + 3, 1500, "post_reset_frames");
        wait_loads(1, l1 + 1, 1500, "post_reset_tdm8");

        allow = '0;
        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", chk, errs);
        $finish;
    end

endmodule
